// File: rtl/stopwatch_pkg.sv
// Shared types and timing constants for the stopwatch key-conditioning logic.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

   localparam int CLK_HZ        = 50_000_000;
   localparam int DEBOUNCE_20MS = CLK_HZ / 50;
   localparam int LONG_1S       = CLK_HZ;
   localparam int REPEAT_200MS  = CLK_HZ / 5;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value; reusable for switch banks.
module sync_2ff #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low pushbutton into a level plus press/release/long-press strobes.
// Optional auto-repeat strobe is enabled by defining KEY_REPEAT_EN.
module key_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int LONG_CYCLES     = LONG_1S,
   parameter int REPEAT_CYCLES   = REPEAT_200MS
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic pressed,
   output logic press_p,
   output logic release_p,
   output logic long_p,
   output logic rpt_p
);

   localparam int               DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam int               HOLD_W   = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("key_debounce: DEBOUNCE_CYCLES must be >= 2, LONG_CYCLES and REPEAT_CYCLES >= 1");
   end

   logic              key_q;
   logic              key_s;
   key_state_t        state;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt;

   // Synchronizer resets to 1 so a key held through reset looks released until sampled.
   sync_2ff #(
      .WIDTH       (1),
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (key_n),
      .q       (key_q)
   );

   assign key_s = ~key_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         db_cnt    <= '0;
         hold_cnt  <= '0;
         pressed   <= 1'b0;
         press_p   <= 1'b0;
         release_p <= 1'b0;
         long_p    <= 1'b0;
      end else begin
         press_p   <= 1'b0;
         release_p <= 1'b0;
         long_p    <= 1'b0;
         case (state)
            IDLE: begin
               if (key_s) begin
                  state  <= PRESS_WAIT;
                  db_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!key_s) begin
                  state <= IDLE;
               end else if (db_cnt == DB_LAST) begin
                  state    <= HELD;
                  press_p  <= 1'b1;
                  pressed  <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            // hold_cnt saturates, so long_p can only fire once per press.
            HELD: begin
               if (!key_s) begin
                  state  <= RELEASE_WAIT;
                  db_cnt <= '0;
               end else if (hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
                  if (hold_cnt == HOLD_PRE) begin
                     long_p <= 1'b1;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (key_s) begin
                  state <= HELD;
               end else if (db_cnt == DB_LAST) begin
                  state     <= IDLE;
                  release_p <= 1'b1;
                  pressed   <= 1'b0;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int              REP_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt;

   // Repeat period only advances in steady HELD after the long press has fired.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rep_cnt <= '0;
         rpt_p   <= 1'b0;
      end else begin
         rpt_p <= 1'b0;
         if (state == IDLE) begin
            rep_cnt <= '0;
         end else if (state == HELD && key_s && hold_cnt == HOLD_MAX) begin
            if (rep_cnt == REP_LAST) begin
               rpt_p   <= 1'b1;
               rep_cnt <= '0;
            end else begin
               rep_cnt <= rep_cnt + REP_W'(1);
            end
         end
      end
   end
`else
   assign rpt_p = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized key activity vs a reference model.
module tb_key_debounce;

   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic key_n = 1'b1;
   logic pressed, press_p, release_p, long_p, rpt_p;

   int errors = 0;
   int checks = 0;

   key_debounce #(
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_n     (key_n),
      .pressed   (pressed),
      .press_p   (press_p),
      .release_p (release_p),
      .long_p    (long_p),
      .rpt_p     (rpt_p)
   );

   always #5 clk = ~clk;

   // Reference model: a level changes once the synchronized key has disagreed with it
   // for D+1 consecutive samples; hold time counts samples with the key steadily down.
   typedef struct {
      bit s1, s2, prev_ks, level;
      int run, hold, rep;
      bit pressed, press, rel, lng, rpt;
   } model_t;

   model_t mdl;

   function automatic model_t model_reset();
      model_t r;
      r.s1 = 1'b1; r.s2 = 1'b1; r.prev_ks = 1'b0; r.level = 1'b0;
      r.run = 0; r.hold = 0; r.rep = 0;
      r.pressed = 1'b0; r.press = 1'b0; r.rel = 1'b0; r.lng = 1'b0; r.rpt = 1'b0;
      return r;
   endfunction

   function automatic model_t model_step(model_t m, bit key);
      model_t n;
      bit ks;
      n = m;
      ks = ~m.s2;
      n.s2 = m.s1;
      n.s1 = key;
      n.press = 1'b0; n.rel = 1'b0; n.lng = 1'b0; n.rpt = 1'b0;
      n.run = (ks != m.level) ? m.run + 1 : 0;
      if (n.run == D + 1) begin
         n.level = ks;
         n.run = 0;
         if (ks) begin
            n.press = 1'b1;
            n.hold = 0;
         end else begin
            n.rel = 1'b1;
            n.rep = 0;
         end
      end else if (m.level && ks && m.prev_ks) begin
         if (m.hold < L) begin
            n.hold = m.hold + 1;
            if (n.hold == L) n.lng = 1'b1;
         end else begin
`ifdef KEY_REPEAT_EN
            n.rep = m.rep + 1;
            if (n.rep == R) begin
               n.rpt = 1'b1;
               n.rep = 0;
            end
`endif
         end
      end
      n.prev_ks = ks;
      n.pressed = n.level;
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) mdl <= model_reset();
      else          mdl <= model_step(mdl, key_n);
   end

   task automatic settle(input int n);
      key_n = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      key_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (pressed !== 1'b0)   begin errors++; $display("FAIL reset_pressed: got %b expected 0", pressed); end
      checks++; if (press_p !== 1'b0)   begin errors++; $display("FAIL reset_press_p: got %b expected 0", press_p); end
      checks++; if (release_p !== 1'b0) begin errors++; $display("FAIL reset_release_p: got %b expected 0", release_p); end
      checks++; if (long_p !== 1'b0)    begin errors++; $display("FAIL reset_long_p: got %b expected 0", long_p); end
      checks++; if (rpt_p !== 1'b0)     begin errors++; $display("FAIL reset_rpt_p: got %b expected 0", rpt_p); end
      reset_n = 1'b1;
      settle(5);
   endtask

   task automatic test_clean_press();
      settle(10);
      key_n = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         checks++; if (press_p !== (c == 7)) begin errors++; $display("FAIL press_p cycle %0d: got %b expected %b", c, press_p, (c == 7)); end
         checks++; if (pressed !== (c >= 7)) begin errors++; $display("FAIL press_level cycle %0d: got %b expected %b", c, pressed, (c >= 7)); end
         checks++; if ({release_p, long_p, rpt_p} !== 3'b000) begin errors++; $display("FAIL press_others cycle %0d: got %b expected 000", c, {release_p, long_p, rpt_p}); end
      end
   endtask

   task automatic test_release();
      key_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         checks++; if (release_p !== (c == 7)) begin errors++; $display("FAIL release_p cycle %0d: got %b expected %b", c, release_p, (c == 7)); end
         checks++; if (pressed !== (c < 7)) begin errors++; $display("FAIL release_level cycle %0d: got %b expected %b", c, pressed, (c < 7)); end
         checks++; if ({press_p, long_p} !== 2'b00) begin errors++; $display("FAIL release_others cycle %0d: got %b expected 00", c, {press_p, long_p}); end
      end
   endtask

   task automatic test_bounce();
      settle(10);
      key_n = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         checks++; if ({pressed, press_p, release_p, long_p} !== 4'b0000) begin errors++; $display("FAIL bounce_press cycle %0d: got %b expected 0000", c, {pressed, press_p, release_p, long_p}); end
         if (c == 3) key_n = 1'b1;
      end
      key_n = 1'b0;
      repeat (10) @(negedge clk);
      key_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         checks++; if (pressed !== 1'b1) begin errors++; $display("FAIL glitch_level cycle %0d: got %b expected 1", c, pressed); end
         checks++; if ({press_p, release_p, long_p} !== 3'b000) begin errors++; $display("FAIL glitch_strobes cycle %0d: got %b expected 000", c, {press_p, release_p, long_p}); end
         if (c == 2) key_n = 1'b0;
      end
      settle(15);
   endtask

   task automatic test_long_hold();
      settle(10);
      key_n = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         checks++; if (press_p !== (c == 7)) begin errors++; $display("FAIL long_press_p cycle %0d: got %b expected %b", c, press_p, (c == 7)); end
         checks++; if (long_p !== (c == 27)) begin errors++; $display("FAIL long_p cycle %0d: got %b expected %b", c, long_p, (c == 27)); end
         checks++; if (pressed !== (c >= 7)) begin errors++; $display("FAIL long_level cycle %0d: got %b expected %b", c, pressed, (c >= 7)); end
      end
      for (int c = 1; c <= 25; c++) begin
         if (c == 3) key_n = 1'b1;
         if (c == 5) key_n = 1'b0;
         @(negedge clk);
         checks++; if (long_p !== 1'b0) begin errors++; $display("FAIL long_once cycle %0d: got %b expected 0", c, long_p); end
         checks++; if (release_p !== 1'b0) begin errors++; $display("FAIL long_no_release cycle %0d: got %b expected 0", c, release_p); end
      end
      settle(15);
   endtask

   task automatic test_repeat();
      bit exp;
      settle(10);
      key_n = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
`ifdef KEY_REPEAT_EN
         exp = (c == 32) || (c == 37);
`else
         exp = 1'b0;
`endif
         checks++; if (rpt_p !== exp) begin errors++; $display("FAIL rpt_p cycle %0d: got %b expected %b", c, rpt_p, exp); end
      end
      settle(15);
   endtask

   task automatic test_reset_mid_held();
      settle(10);
      key_n = 1'b0;
      repeat (12) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++; if ({pressed, press_p, release_p, long_p, rpt_p} !== 5'b00000) begin errors++; $display("FAIL async_reset_outputs: got %b expected 00000", {pressed, press_p, release_p, long_p, rpt_p}); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++; if ({pressed, release_p} !== 2'b00) begin errors++; $display("FAIL in_reset cycle %0d: got %b expected 00", c, {pressed, release_p}); end
      end
      reset_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         checks++; if (press_p !== (c == 7)) begin errors++; $display("FAIL post_reset_press_p cycle %0d: got %b expected %b", c, press_p, (c == 7)); end
         checks++; if (pressed !== (c >= 7)) begin errors++; $display("FAIL post_reset_level cycle %0d: got %b expected %b", c, pressed, (c >= 7)); end
         checks++; if (release_p !== 1'b0) begin errors++; $display("FAIL post_reset_release cycle %0d: got %b expected 0", c, release_p); end
      end
      settle(15);
   endtask

   task automatic test_random();
      int left = 0;
      for (int i = 0; i < 900; i++) begin
         @(negedge clk);
         checks++; if (pressed !== mdl.pressed) begin errors++; $display("FAIL rand_pressed step %0d: got %b expected %b", i, pressed, mdl.pressed); end
         checks++; if (press_p !== mdl.press)   begin errors++; $display("FAIL rand_press_p step %0d: got %b expected %b", i, press_p, mdl.press); end
         checks++; if (release_p !== mdl.rel)   begin errors++; $display("FAIL rand_release_p step %0d: got %b expected %b", i, release_p, mdl.rel); end
         checks++; if (long_p !== mdl.lng)      begin errors++; $display("FAIL rand_long_p step %0d: got %b expected %b", i, long_p, mdl.lng); end
         checks++; if (rpt_p !== mdl.rpt)       begin errors++; $display("FAIL rand_rpt_p step %0d: got %b expected %b", i, rpt_p, mdl.rpt); end
         if (left == 0) begin
            key_n = ~key_n;
            left = ($urandom_range(0, 5) == 0) ? int'($urandom_range(25, 45)) : int'($urandom_range(1, 8));
         end
         left--;
      end
      settle(15);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected bench to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_long_hold();
      test_repeat();
      test_reset_mid_held();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
